// File: rtl/emac_swif_loopback_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | emac_swif_loopback_responder_pkg                                            |
// | State encodings, status bit positions and the byte-enable helper.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package emac_swif_loopback_responder_pkg;

    localparam int c_WORD_W = 32;
    localparam int c_TXS_W  = 18;
    localparam int c_PBL_W  = 9;

    localparam int c_TXS_OVF  = 16;
    localparam int c_TXS_FERR = 17;
    localparam int c_RXS_ERR  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_TXSTAT = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SEND   = 3'd4,
        ST_RXSTAT = 3'd5
    } state_t;

    // be encodes valid bytes of the eof word modulo 4, so 0 means a full word
    function automatic logic [2:0] be_bytes(input logic [1:0] be);
        return (be == 2'd0) ? 3'd4 : {1'b0, be};
    endfunction

endpackage
`default_nettype wire

// File: rtl/emac_swif_loopback_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | emac_swif_loopback_responder_if                                             |
// | ATI (tx) and ARI (rx) switch-interface signals with master/slave views.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface emac_swif_loopback_responder_if;
    import emac_swif_loopback_responder_pkg::*;

    logic                ati_val;
    logic                ati_rdy;
    logic [c_WORD_W-1:0] ati_data;
    logic [1:0]          ati_be;
    logic                ati_sof;
    logic                ati_eof;
    logic [c_PBL_W-1:0]  ati_pbl;
    logic                ati_txstatus_val;
    logic [c_TXS_W-1:0]  ati_txstatus;
    logic                ati_tx_watermark;

    logic                ari_val;
    logic                ari_ack;
    logic [c_WORD_W-1:0] ari_data;
    logic [1:0]          ari_be;
    logic                ari_sof;
    logic                ari_eof;
    logic                ari_rxstatus_val;
    logic [c_PBL_W-1:0]  ari_pbl;
    logic                ari_rx_watermark;
    logic                ari_frameflush;
    logic                ari_timestamp_val;

    modport master (
        output ati_val, ati_data, ati_be, ati_sof, ati_eof, ati_pbl,
        input  ati_rdy, ati_txstatus_val, ati_txstatus, ati_tx_watermark,
        output ari_ack, ari_pbl, ari_frameflush,
        input  ari_val, ari_data, ari_be, ari_sof, ari_eof, ari_rxstatus_val,
        input  ari_rx_watermark, ari_timestamp_val
    );

    modport slave (
        input  ati_val, ati_data, ati_be, ati_sof, ati_eof, ati_pbl,
        output ati_rdy, ati_txstatus_val, ati_txstatus, ati_tx_watermark,
        input  ari_ack, ari_pbl, ari_frameflush,
        output ari_val, ari_data, ari_be, ari_sof, ari_eof, ari_rxstatus_val,
        output ari_rx_watermark, ari_timestamp_val
    );

endinterface
`default_nettype wire

// File: rtl/emac_swif_loopback_responder_frame_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | emac_swif_loopback_responder_frame_ram                                      |
// | Simple dual-port frame buffer: one write port, one registered read port.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module emac_swif_loopback_responder_frame_ram
    import emac_swif_loopback_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic                clk,
    input  wire logic                i_we,
    input  wire logic [ADDR_W-1:0]   i_waddr,
    input  wire logic [c_WORD_W-1:0] i_wdata,
    input  wire logic                i_re,
    input  wire logic [ADDR_W-1:0]   i_raddr,
    output logic      [c_WORD_W-1:0] o_rdata
);

    logic [c_WORD_W-1:0] r_mem [2**ADDR_W];
    logic [c_WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read data only advances on i_re so the output holds during consumer stalls
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/emac_swif_loopback_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | emac_swif_loopback_responder                                                |
// | EMAC stand-in: takes one ATI frame, reports tx status, replays it on ARI.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module emac_swif_loopback_responder #(
    parameter int ADDR_W   = 10,
    parameter bit DROP_ERR = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    emac_swif_loopback_responder_if.slave bus
);
    import emac_swif_loopback_responder_pkg::*;

    localparam logic [ADDR_W:0]   c_DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_ONE_W   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic                r_rdy;
    logic [ADDR_W:0]     r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_out_idx;
    logic [ADDR_W:0]     r_words;
    logic                r_ovf;
    logic                r_ferr;
    logic [1:0]          r_eof_be;
    logic [15:0]         r_len;

    logic                w_take;
    logic                w_ack;
    logic                w_flush;
    logic                w_last;
    logic                w_err;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [ADDR_W:0]     w_cnt;
    logic [15:0]         w_len;
    logic                w_re;
    logic [ADDR_W-1:0]   w_raddr;
    logic [c_WORD_W-1:0] w_rdata;
    logic [ADDR_W:0]     w_free;
    logic [ADDR_W:0]     w_remain;
    logic [c_PBL_W-1:0]  w_tx_thr;
    logic [c_PBL_W-1:0]  w_rx_thr;
    logic [c_TXS_W-1:0]  w_txs;
    logic [c_WORD_W-1:0] w_rxs;

    assign w_take  = bus.ati_val && r_rdy;
    assign w_ack   = (r_state == ST_SEND) && bus.ari_ack;
    assign w_flush = bus.ari_frameflush &&
                     ((r_state == ST_LOAD) || (r_state == ST_SEND) || (r_state == ST_RXSTAT));
    assign w_last  = (r_out_idx == (r_words - c_ONE_W));
    assign w_err   = r_ovf || r_ferr;

    // Write side; w_cnt is the stored word count after this word, i.e. the next wr_ptr
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_cnt   = r_wr_ptr;
        if (w_take) begin
            if (bus.ati_sof) begin
                w_we    = (r_state == ST_IDLE) || (r_state == ST_RECV);
                w_cnt   = c_ONE_W;
            end else if (r_state == ST_RECV) begin
                if (r_wr_ptr == c_DEPTH_W) begin
                    w_cnt   = c_DEPTH_W;
                end else begin
                    w_we    = 1'b1;
                    w_waddr = r_wr_ptr[ADDR_W-1:0];
                    w_cnt   = r_wr_ptr + c_ONE_W;
                end
            end
        end
    end

    assign w_len = ((16'(w_cnt) - 16'd1) << 2) + {13'd0, be_bytes(bus.ati_be)};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_take && bus.ati_sof) w_next = bus.ati_eof ? ST_TXSTAT : ST_RECV;
            ST_RECV:   if (w_take && bus.ati_eof) w_next = ST_TXSTAT;
            ST_TXSTAT: w_next = (w_err && DROP_ERR) ? ST_IDLE : ST_LOAD;
            ST_LOAD:   w_next = ST_SEND;
            ST_SEND:   if (w_ack && w_last) w_next = ST_RXSTAT;
            ST_RXSTAT: if (bus.ari_ack) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_flush) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_out_idx <= '0;
            r_words   <= '0;
            r_ovf     <= 1'b0;
            r_ferr    <= 1'b0;
            r_eof_be  <= 2'd0;
            r_len     <= 16'd0;
        end else begin
            r_rdy <= (w_next == ST_IDLE) || (w_next == ST_RECV);
            if (w_take && ((r_state == ST_RECV) || (r_state == ST_IDLE && bus.ati_sof))) begin
                r_wr_ptr <= w_cnt;
                if (r_state == ST_IDLE) begin
                    r_ovf  <= 1'b0;
                    r_ferr <= 1'b0;
                end else if (bus.ati_sof) begin
                    r_ferr <= 1'b1;
                end else if (r_wr_ptr == c_DEPTH_W) begin
                    r_ovf  <= 1'b1;
                end
                if (bus.ati_eof) begin
                    r_words  <= w_cnt;
                    r_len    <= w_len;
                    r_eof_be <= bus.ati_be;
                end
            end
            if (r_state == ST_LOAD) begin
                r_rd_ptr  <= c_ONE_A;
                r_out_idx <= '0;
            end else if (w_ack) begin
                r_rd_ptr  <= r_rd_ptr + c_ONE_A;
                r_out_idx <= r_out_idx + c_ONE_W;
            end
        end
    end

    // Look-ahead: the next word is fetched on the same edge that retires the current one
    assign w_re    = (r_state == ST_LOAD) || w_ack;
    assign w_raddr = (r_state == ST_LOAD) ? '0 : r_rd_ptr;

    emac_swif_loopback_responder_frame_ram #(
        .ADDR_W (ADDR_W)
    ) u_frame_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.ati_data),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign w_tx_thr = (bus.ati_pbl == '0) ? 9'd1 : bus.ati_pbl;
    assign w_rx_thr = (bus.ari_pbl == '0) ? 9'd1 : bus.ari_pbl;
    assign w_free   = c_DEPTH_W - ((r_state == ST_RECV) ? r_wr_ptr : '0);
    assign w_remain = r_words - r_out_idx;

    always_comb begin
        w_txs             = '0;
        w_txs[15:0]       = r_len;
        w_txs[c_TXS_OVF]  = r_ovf;
        w_txs[c_TXS_FERR] = r_ferr;
        w_rxs             = '0;
        w_rxs[15:0]       = r_len;
        w_rxs[c_RXS_ERR]  = w_err;
    end

    assign bus.ati_rdy          = r_rdy;
    assign bus.ati_txstatus_val = (r_state == ST_TXSTAT);
    assign bus.ati_txstatus     = (r_state == ST_TXSTAT) ? w_txs : '0;
    assign bus.ati_tx_watermark = r_rdy && (16'(w_free) >= 16'(w_tx_thr));

    assign bus.ari_val           = (r_state == ST_SEND);
    assign bus.ari_data          = (r_state == ST_SEND)   ? w_rdata :
                                   (r_state == ST_RXSTAT) ? w_rxs   : '0;
    assign bus.ari_sof           = (r_state == ST_SEND) && (r_out_idx == '0);
    assign bus.ari_eof           = (r_state == ST_SEND) && w_last;
    assign bus.ari_be            = ((r_state == ST_SEND) && w_last) ? r_eof_be : 2'd0;
    assign bus.ari_rxstatus_val  = (r_state == ST_RXSTAT);
    assign bus.ari_rx_watermark  = (r_state == ST_SEND) && (16'(w_remain) >= 16'(w_rx_thr));
    assign bus.ari_timestamp_val = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_emac_swif_loopback_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_emac_swif_loopback_responder                                             |
// | Directed bench: two responder builds (ADDR_W=4/DROP_ERR=1, 10/0).           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_emac_swif_loopback_responder;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        t_val, t_sof, t_eof, t_ack, t_flush;
    logic [31:0] t_data;
    logic [1:0]  t_be;
    int          n_cmp;
    int          n_err;

    emac_swif_loopback_responder_if ifa ();
    emac_swif_loopback_responder_if ifb ();

    assign ifa.ati_val        = t_val && !sel;
    assign ifa.ati_data       = t_data;
    assign ifa.ati_be         = t_be;
    assign ifa.ati_sof        = t_sof;
    assign ifa.ati_eof        = t_eof;
    assign ifa.ati_pbl        = 9'd4;
    assign ifa.ari_ack        = t_ack && !sel;
    assign ifa.ari_pbl        = 9'd2;
    assign ifa.ari_frameflush = t_flush && !sel;

    assign ifb.ati_val        = t_val && sel;
    assign ifb.ati_data       = t_data;
    assign ifb.ati_be         = t_be;
    assign ifb.ati_sof        = t_sof;
    assign ifb.ati_eof        = t_eof;
    assign ifb.ati_pbl        = 9'd4;
    assign ifb.ari_ack        = t_ack && sel;
    assign ifb.ari_pbl        = 9'd2;
    assign ifb.ari_frameflush = t_flush && sel;

    emac_swif_loopback_responder #(.ADDR_W(4), .DROP_ERR(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    emac_swif_loopback_responder #(.ADDR_W(10), .DROP_ERR(1'b0)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    logic        o_rdy, o_txv, o_txwm, o_av, o_asof, o_aeof, o_arxv, o_arwm, o_ats;
    logic [17:0] o_txs;
    logic [31:0] o_ad;
    logic [1:0]  o_abe;

    assign o_rdy  = sel ? ifb.ati_rdy           : ifa.ati_rdy;
    assign o_txv  = sel ? ifb.ati_txstatus_val  : ifa.ati_txstatus_val;
    assign o_txs  = sel ? ifb.ati_txstatus      : ifa.ati_txstatus;
    assign o_txwm = sel ? ifb.ati_tx_watermark  : ifa.ati_tx_watermark;
    assign o_av   = sel ? ifb.ari_val           : ifa.ari_val;
    assign o_ad   = sel ? ifb.ari_data          : ifa.ari_data;
    assign o_abe  = sel ? ifb.ari_be            : ifa.ari_be;
    assign o_asof = sel ? ifb.ari_sof           : ifa.ari_sof;
    assign o_aeof = sel ? ifb.ari_eof           : ifa.ari_eof;
    assign o_arxv = sel ? ifb.ari_rxstatus_val  : ifa.ari_rxstatus_val;
    assign o_arwm = sel ? ifb.ari_rx_watermark  : ifa.ari_rx_watermark;
    assign o_ats  = sel ? ifb.ari_timestamp_val : ifa.ari_timestamp_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [1:0] be,
                             input logic s, input logic e);
        int k;
        k = 0;
        @(negedge clk);
        t_val = 1'b1; t_data = d; t_be = be; t_sof = s; t_eof = e;
        while (o_rdy !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ati_accept", {31'd0, o_rdy}, 32'd1);
    endtask

    task automatic send_frame(input logic [31:0] base, input int n,
                              input logic [1:0] be, input int restart_at,
                              input logic [17:0] txs);
        for (int i = 0; i < n; i++) begin
            send_word(base + i, be, (i == 0) || (i == restart_at), i == n - 1);
        end
        @(negedge clk);
        t_val = 1'b0; t_sof = 1'b0; t_eof = 1'b0;
        chk("txstatus_val", {31'd0, o_txv}, 32'd1);
        chk("txstatus", {14'd0, o_txs}, {14'd0, txs});
        chk("ati_rdy_busy", {31'd0, o_rdy}, 32'd0);
        @(negedge clk);
        chk("txstatus_pulse", {31'd0, o_txv}, 32'd0);
    endtask

    task automatic recv_frame(input logic [31:0] base, input int n, input logic [1:0] be,
                              input bit toggle, input int flush_at, input logic [31:0] sts);
        int got;
        int cyc;
        bit flushed;
        got = 0; cyc = 0; flushed = 1'b0;
        while (got < n && !flushed && cyc < 200) begin
            @(negedge clk);
            cyc++;
            t_ack = 1'b0;
            if (o_av === 1'b1) begin
                chk("rx_data", o_ad, base + got);
                chk("rx_flags", {28'd0, o_asof, o_aeof, o_abe},
                    {28'd0, got == 0, got == n - 1, (got == n - 1) ? be : 2'd0});
                chk("rx_watermark", {31'd0, o_arwm}, {31'd0, (n - got) >= 2});
                if (got == flush_at) begin
                    t_flush = 1'b1;
                    flushed = 1'b1;
                end else if (!toggle || cyc[0]) begin
                    t_ack = 1'b1;
                    got++;
                end
            end
        end
        if (flushed) begin
            @(negedge clk);
            t_flush = 1'b0;
            chk("flush_val_low", {31'd0, o_av}, 32'd0);
            chk("flush_no_rxstat", {31'd0, o_arxv}, 32'd0);
            chk("flush_idle_rdy", {31'd0, o_rdy}, 32'd1);
        end else begin
            chk("rx_count", got, n);
            @(negedge clk);
            t_ack = 1'b0;
            chk("rxstatus_val", {31'd0, o_arxv}, 32'd1);
            chk("rxstatus", o_ad, sts);
            chk("rx_val_low", {31'd0, o_av}, 32'd0);
            @(negedge clk);
            chk("rxstatus_held", {31'd0, o_arxv}, 32'd1);
            t_ack = 1'b1;
            @(negedge clk);
            t_ack = 1'b0;
            chk("rx_done_rdy", {31'd0, o_rdy}, 32'd1);
            chk("rxstatus_clear", {31'd0, o_arxv}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; sel = 1'b0;
        t_val = 1'b0; t_sof = 1'b0; t_eof = 1'b0; t_ack = 1'b0; t_flush = 1'b0;
        t_data = 32'd0; t_be = 2'd0;

        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, o_rdy}, 32'd0);
        chk("rst_outs", {26'd0, o_txv, o_txwm, o_av, o_arxv, o_arwm, o_ats}, 32'd0);
        chk("rst_txs", {14'd0, o_txs}, 32'd0);
        chk("rst_ari_data", o_ad, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {31'd0, o_rdy}, 32'd1);
        chk("idle_tx_wm", {31'd0, o_txwm}, 32'd1);

        // 4 words, be=2: length 14
        send_frame(32'hA100_0000, 4, 2'd2, -1, 18'h0000E);
        recv_frame(32'hA100_0000, 4, 2'd2, 1'b0, -1, 32'h0000_000E);

        // single word, sof+eof, be=0: length 4
        send_frame(32'hA200_0000, 1, 2'd0, -1, 18'h00004);
        recv_frame(32'hA200_0000, 1, 2'd0, 1'b0, -1, 32'h0000_0004);

        // 8 words, be=3, ack toggling: length 31
        send_frame(32'hA300_0000, 8, 2'd3, -1, 18'h0001F);
        recv_frame(32'hA300_0000, 8, 2'd3, 1'b1, -1, 32'h0000_001F);

        // flush during replay of word 2, then a normal 3-word frame (be=1: length 9)
        send_frame(32'hA400_0000, 5, 2'd0, -1, 18'h00014);
        recv_frame(32'hA400_0000, 5, 2'd0, 1'b0, 2, 32'h0);
        send_frame(32'hA500_0000, 3, 2'd1, -1, 18'h00009);
        recv_frame(32'hA500_0000, 3, 2'd1, 1'b0, -1, 32'h0000_0009);

        // 20 words into a 16-word buffer: overflow, length 64, dropped
        send_frame(32'hA600_0000, 20, 2'd0, -1, 18'h10040);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_av !== 1'b0 || o_arxv !== 1'b0) saw = 1'b1;
        end
        chk("drop_no_ari", {31'd0, saw}, 32'd0);
        chk("drop_idle_rdy", {31'd0, o_rdy}, 32'd1);

        // second build replays errored frames: restart at word 3 of 6
        sel = 1'b1;
        @(negedge clk);
        chk("b_idle_rdy", {31'd0, o_rdy}, 32'd1);
        send_frame(32'hB000_0000, 6, 2'd0, 3, 18'h2000C);
        recv_frame(32'hB000_0003, 3, 2'd0, 1'b0, -1, 32'h0001_000C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
